// File: rtl/midori_sbox_sched.sv
// Byte-serial scheduler for one shared, 3-share masked Midori S-box pair over a 64-bit state.
// Optional build macro: BUBBLE_ZERO_EN (zero sb_in*/sb_r on non-issue cycles instead of holding).
module midori_sbox_sched #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned NBYTE   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*NBYTE-1:0] state_in1,
  input  logic [8*NBYTE-1:0] state_in2,
  input  logic [8*NBYTE-1:0] state_in3,
  output logic               busy,
  output logic               done,
  output logic [8*NBYTE-1:0] state_out1,
  output logic [8*NBYTE-1:0] state_out2,
  output logic [8*NBYTE-1:0] state_out3,
  input  logic [89:0]        rnd_data,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [7:0]         sb_in1,
  output logic [7:0]         sb_in2,
  output logic [7:0]         sb_in3,
  output logic [89:0]        sb_r,
  input  logic [7:0]         sb_out1,
  input  logic [7:0]         sb_out2,
  input  logic [7:0]         sb_out3
);

  localparam int unsigned IW = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  typedef enum logic [1:0] {
    st_idle,
    st_feed,
    st_drain,
    st_done
  } state_t;

  state_t                        state_q, state_d;
  logic   [IW-1:0]               idx_q;
  logic   [8*NBYTE-1:0]          sh1_q, sh2_q, sh3_q;
  logic   [LATENCY-1:0]          tag_v_q;
  logic   [LATENCY-1:0][IW-1:0]  tag_idx_q;
  logic                          issue;
  logic                          pending;

  assign issue     = (state_q == st_feed) && rnd_valid;
  assign rnd_ready = (state_q == st_feed);
  assign busy      = (state_q == st_feed) || (state_q == st_drain);
  assign done      = (state_q == st_done);

  // The registered sb_in*/sb_r stage is the first of the LATENCY pipeline stages, so a tag
  // leaving the last stage lines up with the matching sb_out* word.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < int'(LATENCY) - 1; k++) begin
      pending = pending | tag_v_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      st_idle:  if (start) state_d = st_feed;
      st_feed:  if (rnd_valid && (idx_q == IW'(NBYTE - 1))) state_d = st_drain;
      st_drain: if (!pending) state_d = st_done;
      st_done:  state_d = st_idle;
      default:  state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= st_idle;
      idx_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      sh3_q      <= '0;
      tag_v_q    <= '0;
      tag_idx_q  <= '0;
      sb_in1     <= '0;
      sb_in2     <= '0;
      sb_in3     <= '0;
      sb_r       <= '0;
      state_out1 <= '0;
      state_out2 <= '0;
      state_out3 <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == st_idle) && start) begin
        idx_q <= '0;
        sh1_q <= state_in1;
        sh2_q <= state_in2;
        sh3_q <= state_in3;
      end else if (issue) begin
        idx_q <= idx_q + 1'b1;
      end

      tag_v_q[0]   <= issue;
      tag_idx_q[0] <= idx_q;
      for (int k = 1; k < int'(LATENCY); k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end

      if (issue) begin
        sb_in1 <= sh1_q[{idx_q, 3'b000} +: 8];
        sb_in2 <= sh2_q[{idx_q, 3'b000} +: 8];
        sb_in3 <= sh3_q[{idx_q, 3'b000} +: 8];
        sb_r   <= rnd_data;
      end else begin
`ifdef BUBBLE_ZERO_EN
        sb_in1 <= '0;
        sb_in2 <= '0;
        sb_in3 <= '0;
        sb_r   <= '0;
`else
        // Hold so the masked S-box inputs do not toggle on bubbles.
        sb_in1 <= sb_in1;
        sb_in2 <= sb_in2;
        sb_in3 <= sb_in3;
        sb_r   <= sb_r;
`endif
      end

      if (tag_v_q[LATENCY-1]) begin
        state_out1[{tag_idx_q[LATENCY-1], 3'b000} +: 8] <= sb_out1;
        state_out2[{tag_idx_q[LATENCY-1], 3'b000} +: 8] <= sb_out2;
        state_out3[{tag_idx_q[LATENCY-1], 3'b000} +: 8] <= sb_out3;
      end
    end
  end

endmodule
